// File: rtl/acc_array.sv
// ----------------------------------------------------------------------------
// acc_array -- multi-channel running-sum accumulator.
//
// Tagged samples arrive over a valid/ready handshake. Each accepted sample is
// added to the running sum of its channel, and the updated {channel, sum,
// sticky overflow flag} is presented through a single registered output stage
// with backpressure. A side-band clear zeroes one channel's sum and flag.
//
// Optional feature macro: ACC_SAT_EN
//   defined   -> a sum that carries out clamps to 2^SUM_W-1
//   undefined -> a sum that carries out wraps modulo 2^SUM_W
//   The sticky overflow flag is set on carry in both builds.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake; in_ready = !out_valid || out_ready
//   in_ch, in_data    target channel and unsigned sample value
//   clr, clr_ch       clear request (no handshake) and channel to clear
//   out_valid/ready   result handshake
//   out_ch, out_sum   channel and its sum after the sample
//   out_ovf           that channel's sticky flag, including this sample
//   ovf_vec           live sticky overflow flags, one bit per channel
// ----------------------------------------------------------------------------
module acc_array #(
    parameter int  IN_W  = 8,
    parameter int  SUM_W = 16,
    parameter int  NCH   = 4,
    localparam int CH_W  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [IN_W-1:0]  in_data,
    input  logic             clr,
    input  logic [CH_W-1:0]  clr_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [NCH-1:0]   ovf_vec
);

    // Per-channel state
    logic [SUM_W-1:0] sum_q [NCH];
    logic [SUM_W-1:0] sum_d [NCH];
    logic [NCH-1:0]   flag_q, flag_d;

    // Result register
    logic             out_valid_q, out_valid_d;
    logic [CH_W-1:0]  out_ch_q,    out_ch_d;
    logic [SUM_W-1:0] out_sum_q,   out_sum_d;
    logic             out_ovf_q,   out_ovf_d;

    // Datapath for the accepted sample
    logic             accept;
    logic             in_hit;
    logic             clr_hit;
    logic [SUM_W-1:0] base_sum;
    logic             base_flag;
    logic [SUM_W:0]   raw_sum;
    logic [SUM_W-1:0] new_sum;
    logic             new_flag;

    // in_ready depends only on the output stage, never on in_valid.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Out-of-range channels (non-power-of-two NCH) are swallowed silently.
    assign in_hit   = accept && (32'(in_ch) < NCH);
    assign clr_hit  = clr && (32'(clr_ch) < NCH);

    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        base_sum  = '0;
        base_flag = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (in_ch == CH_W'(i)) begin
                base_sum  = sum_q[i];
                base_flag = flag_q[i];
            end
        end
        // A clear on the same channel in the same cycle acts first, so the
        // sample is added to zero and the old flag is forgotten.
        if (clr_hit && (clr_ch == in_ch)) begin
            base_sum  = '0;
            base_flag = 1'b0;
        end
        raw_sum  = {1'b0, base_sum} + {{(SUM_W + 1 - IN_W){1'b0}}, in_data};
        new_flag = base_flag | raw_sum[SUM_W];
`ifdef ACC_SAT_EN
        new_sum  = raw_sum[SUM_W] ? '1 : raw_sum[SUM_W-1:0];
`else
        new_sum  = raw_sum[SUM_W-1:0];
`endif
    end

    always_comb begin
        flag_d      = flag_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        for (int i = 0; i < NCH; i++) begin
            sum_d[i] = sum_q[i];
            if (clr_hit && (clr_ch == CH_W'(i))) begin
                sum_d[i]  = '0;
                flag_d[i] = 1'b0;
            end
            // The accept path already folded in any same-channel clear.
            if (in_hit && (in_ch == CH_W'(i))) begin
                sum_d[i]  = new_sum;
                flag_d[i] = new_flag;
            end
        end

        if (in_hit) begin
            out_valid_d = 1'b1;
            out_ch_d    = in_ch;
            out_sum_d   = new_sum;
            out_ovf_d   = new_flag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    // NOTE: the sum array is small register storage, not a RAM macro, so it is
    // reset together with the rest of the state; reset must discard all sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                sum_q[i] <= '0;
            end
            flag_q      <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sum_q[i] <= sum_d[i];
            end
            flag_q      <= flag_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign ovf_vec   = flag_q;

endmodule

// File: tb/tb_acc_array.sv
// ----------------------------------------------------------------------------
// tb_acc_array -- self-checking bench for acc_array (default parameters).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point. A behavioural model tracks per-channel sums, sticky flags
// and the expected result register. Honours ACC_SAT_EN like the design.
// ----------------------------------------------------------------------------
module tb_acc_array;

    localparam int    IN_W  = 8;
    localparam int    SUM_W = 16;
    localparam int    NCH   = 4;
    localparam int    CH_W  = $clog2(NCH);
    localparam longint MAXV = (64'd1 << SUM_W) - 1;
`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_ch;
    logic [IN_W-1:0]  in_data;
    logic             clr;
    logic [CH_W-1:0]  clr_ch;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [SUM_W-1:0] out_sum;
    logic             out_ovf;
    logic [NCH-1:0]   ovf_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    longint         m_sum [NCH];
    logic [NCH-1:0] m_flag;
    logic           e_valid;
    int             e_ch;
    longint         e_sum;
    logic           e_ovf;

    acc_array #(.IN_W(IN_W), .SUM_W(SUM_W), .NCH(NCH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .in_data  (in_data),
        .clr      (clr),
        .clr_ch   (clr_ch),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf),
        .ovf_vec  (ovf_vec)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_sum[i] = 0;
        m_flag  = '0;
        e_valid = 1'b0;
        e_ch    = 0;
        e_sum   = 0;
        e_ovf   = 1'b0;
    endtask

    // Advance the model by the rules of one clock edge, then the clock itself.
    task automatic tick();
        bit     rdy;
        bit     acc;
        longint s;
        rdy = !e_valid || out_ready;
        acc = in_valid && rdy;
        if (clr) begin
            m_sum[clr_ch]  = 0;
            m_flag[clr_ch] = 1'b0;
        end
        if (acc) begin
            s = m_sum[in_ch] + longint'(in_data);
            if (s > MAXV) begin
                m_flag[in_ch] = 1'b1;
                s = SAT ? MAXV : s - (MAXV + 1);
            end
            m_sum[in_ch] = s;
            e_valid = 1'b1;
            e_ch    = int'(in_ch);
            e_sum   = s;
            e_ovf   = m_flag[in_ch];
        end else if (out_ready) begin
            e_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int ch, input int data);
        in_valid = v;
        in_ch    = CH_W'(ch);
        in_data  = IN_W'(data);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_ch = 0; in_data = 0;
        clr = 0; clr_ch = 0; out_ready = 1;
        model_reset();
        #12;
        n_checks++;
        if (out_valid !== 0 || out_ch !== 0 || out_sum !== 0 || out_ovf !== 0 || ovf_vec !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b ch=%0d sum=%0d ovf=%b vec=%b, expected all 0",
                     out_valid, out_ch, out_sum, out_ovf, ovf_vec);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int vals [3] = '{10, 20, 30};
        int sums [3] = '{10, 30, 60};
        out_ready = 1;
        foreach (vals[i]) begin
            drive(1, 0, vals[i]);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL basic_ready[%0d]: got %b expected 1", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1 || out_ch !== 0 || out_sum !== SUM_W'(sums[i]) || out_ovf !== 0) begin
                n_fail++;
                $display("FAIL basic[%0d]: got v=%b ch=%0d sum=%0d ovf=%b, expected v=1 ch=0 sum=%0d ovf=0",
                         i, out_valid, out_ch, out_sum, out_ovf, sums[i]);
            end
        end
        drive(0, 0, 0);
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_interleave();
        int chs  [3] = '{1, 2, 1};
        int vals [3] = '{255, 1, 1};
        int sums [3] = '{255, 1, 256};
        out_ready = 1;
        foreach (chs[i]) begin
            drive(1, chs[i], vals[i]);
            tick();
            n_checks++;
            if (out_valid !== 1 || out_ch !== CH_W'(chs[i]) || out_sum !== SUM_W'(sums[i]) || ovf_vec !== 0) begin
                n_fail++;
                $display("FAIL interleave[%0d]: got v=%b ch=%0d sum=%0d vec=%b, expected v=1 ch=%0d sum=%0d vec=0",
                         i, out_valid, out_ch, out_sum, ovf_vec, chs[i], sums[i]);
            end
        end
        drive(0, 0, 0);
        tick();
    endtask

    task automatic test_overflow();
        longint exp1;
        longint exp2;
        exp1 = SAT ? MAXV : 4;
        exp2 = SAT ? MAXV : 5;
        out_ready = 1;
        for (int i = 0; i < 257; i++) begin
            drive(1, 3, (i == 256) ? 250 : 255);
            tick();
            n_checks++;
            if (out_valid !== 1 || out_ch !== 3 || out_sum !== SUM_W'(e_sum) || out_ovf !== 0) begin
                n_fail++;
                $display("FAIL preload[%0d]: got v=%b ch=%0d sum=%0d ovf=%b, expected v=1 ch=3 sum=%0d ovf=0",
                         i, out_valid, out_ch, out_sum, out_ovf, e_sum);
            end
        end
        n_checks++;
        if (out_sum !== 16'd65530) begin
            n_fail++; $display("FAIL preload_total: got %0d expected 65530", out_sum);
        end
        drive(1, 3, 10);
        tick();
        n_checks++;
        if (out_sum !== SUM_W'(exp1) || out_ovf !== 1 || ovf_vec[3] !== 1) begin
            n_fail++;
            $display("FAIL ovf_add: got sum=%0d ovf=%b vec=%b, expected sum=%0d ovf=1 vec[3]=1",
                     out_sum, out_ovf, ovf_vec, exp1);
        end
        drive(1, 3, 1);
        tick();
        n_checks++;
        if (out_sum !== SUM_W'(exp2) || out_ovf !== 1 || ovf_vec !== 4'b1000) begin
            n_fail++;
            $display("FAIL ovf_after: got sum=%0d ovf=%b vec=%b, expected sum=%0d ovf=1 vec=1000",
                     out_sum, out_ovf, ovf_vec, exp2);
        end
        drive(0, 0, 0);
        tick();
    endtask

    task automatic test_stall();
        logic [CH_W-1:0]  h_ch;
        logic [SUM_W-1:0] h_sum;
        logic             h_ovf;
        out_ready = 1;
        drive(1, 2, 7);
        tick();
        n_checks++;
        if (out_valid !== 1 || out_ch !== 2 || out_sum !== 16'd8) begin
            n_fail++; $display("FAIL stall_first: got v=%b ch=%0d sum=%0d expected v=1 ch=2 sum=8",
                               out_valid, out_ch, out_sum);
        end
        h_ch = out_ch; h_sum = out_sum; h_ovf = out_ovf;
        out_ready = 0;
        drive(1, 1, 3);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1 || out_ch !== h_ch || out_sum !== h_sum || out_ovf !== h_ovf) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b ch=%0d sum=%0d ovf=%b expected v=1 ch=%0d sum=%0d ovf=%b",
                         i, out_valid, out_ch, out_sum, out_ovf, h_ch, h_sum, h_ovf);
            end
        end
        out_ready = 1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_ready: got %b expected 1", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1 || out_ch !== 1 || out_sum !== 16'd259) begin
            n_fail++; $display("FAIL stall_release: got v=%b ch=%0d sum=%0d expected v=1 ch=1 sum=259",
                               out_valid, out_ch, out_sum);
        end
        drive(0, 0, 0);
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_clear();
        out_ready = 1;
        // Clear alone: channel 0 zeroed, result register untouched (idle).
        clr = 1; clr_ch = 0;
        tick();
        clr = 0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL clr_no_result: got out_valid=%b expected 0", out_valid);
        end
        drive(1, 0, 100);
        tick();
        n_checks++;
        if (out_sum !== 16'd100 || out_ch !== 0) begin
            n_fail++; $display("FAIL clr_load100: got ch=%0d sum=%0d expected ch=0 sum=100", out_ch, out_sum);
        end
        clr = 1; clr_ch = 0;
        drive(1, 0, 7);
        tick();
        clr = 0;
        n_checks++;
        if (out_valid !== 1 || out_ch !== 0 || out_sum !== 16'd7 || out_ovf !== 0) begin
            n_fail++; $display("FAIL clr_same: got v=%b ch=%0d sum=%0d ovf=%b expected v=1 ch=0 sum=7 ovf=0",
                               out_valid, out_ch, out_sum, out_ovf);
        end
        // Clear ch1 while accepting into ch2 (currently 8).
        clr = 1; clr_ch = 1;
        drive(1, 2, 5);
        tick();
        clr = 0;
        n_checks++;
        if (out_ch !== 2 || out_sum !== 16'd13) begin
            n_fail++; $display("FAIL clr_diff: got ch=%0d sum=%0d expected ch=2 sum=13", out_ch, out_sum);
        end
        drive(1, 1, 4);
        tick();
        n_checks++;
        if (out_ch !== 1 || out_sum !== 16'd4) begin
            n_fail++; $display("FAIL clr_diff_after: got ch=%0d sum=%0d expected ch=1 sum=4", out_ch, out_sum);
        end
        drive(0, 0, 0);
        clr = 1; clr_ch = 3;
        tick();
        clr = 0;
        n_checks++;
        if (ovf_vec[3] !== 1'b0 || ovf_vec !== m_flag) begin
            n_fail++; $display("FAIL clr_flag3: got vec=%b expected %b", ovf_vec, m_flag);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = CH_W'($urandom_range(0, NCH - 1));
            in_data   = ($urandom_range(0, 3) == 0) ? IN_W'(255) : IN_W'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 15) == 0);
            clr_ch    = CH_W'($urandom_range(0, NCH - 1));
            #1;
            n_checks++;
            if (in_ready !== (!e_valid || out_ready)) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, in_ready, !e_valid || out_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== e_valid || ovf_vec !== m_flag ||
                (e_valid && (out_ch !== CH_W'(e_ch) || out_sum !== SUM_W'(e_sum) || out_ovf !== e_ovf))) begin
                n_fail++;
                $display("FAIL rand[%0d]: got v=%b ch=%0d sum=%0d ovf=%b vec=%b expected v=%b ch=%0d sum=%0d ovf=%b vec=%b",
                         i, out_valid, out_ch, out_sum, out_ovf, ovf_vec, e_valid, e_ch, e_sum, e_ovf, m_flag);
            end
        end
        clr = 0;
        drive(0, 0, 0);
        out_ready = 1;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1;
        drive(1, 1, 9);
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre: got out_valid=%b expected 1", out_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 0 || out_ch !== 0 || out_sum !== 0 || out_ovf !== 0 || ovf_vec !== 0) begin
            n_fail++;
            $display("FAIL arst_outputs: got v=%b ch=%0d sum=%0d ovf=%b vec=%b, expected all 0",
                     out_valid, out_ch, out_sum, out_ovf, ovf_vec);
        end
        drive(0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 0, 5);
        tick();
        n_checks++;
        if (out_valid !== 1 || out_ch !== 0 || out_sum !== 16'd5 || out_ovf !== 0) begin
            n_fail++; $display("FAIL arst_after: got v=%b ch=%0d sum=%0d ovf=%b expected v=1 ch=0 sum=5 ovf=0",
                               out_valid, out_ch, out_sum, out_ovf);
        end
        drive(0, 0, 0);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interleave();
        test_overflow();
        test_stall();
        test_clear();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_array.md
# acc_array

Parametrised multi-channel accumulator; successor to the single-channel 8-bit/16-bit accumulator. Accepts tagged samples over a valid/ready handshake, keeps one running sum per channel, and returns the updated sum for every accepted sample through a one-stage registered output with backpressure. Per-channel clear, sticky overflow flags and optional saturation cover multi-stream use in the same testbench environment (clocking-block driven stimulus, sampled outputs).

## Interface
- `IN_W`, 8, sample width, unsigned
- `SUM_W`, 16, accumulator width per channel, must be > IN_W
- `NCH`, 4, channel count, ≥ 2; `CH_W` = $clog2(NCH) derived
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  sample present
- `in_ready`  out  1  block can accept sample this cycle
- `in_ch`  in  CH_W  target channel
- `in_data`  in  IN_W  sample value
- `clr`  in  1  clear request, no handshake, acted on every cycle it is high
- `clr_ch`  in  CH_W  channel to clear
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `out_ch`  out  CH_W  channel of result
- `out_sum`  out  SUM_W  channel sum after the sample
- `out_ovf`  out  1  sticky overflow flag of that channel, including this sample
- `ovf_vec`  out  NCH  live sticky overflow flags, one bit per channel

## Operation
- Reset: all sums 0, all flags 0, `out_valid`=0, `out_ch`=0, `out_sum`=0, `out_ovf`=0, `ovf_vec`=0. `in_ready`=1 immediately after reset.
- Accept: `in_valid && in_ready` at an edge. That edge updates sum[in_ch] ← sum[in_ch] + in_data. The sum is computed at SUM_W+1 bits; the carry bit sets flag[in_ch].
- Result register: loads {in_ch, new sum, new flag} on every accept and sets `out_valid`. Holds stable while `out_valid && !out_ready`.
- Handshake: `in_ready = !out_valid || out_ready`, combinational from `out_ready`. `in_valid` is never combinationally used to form `in_ready`. `out_valid` falls on the edge where `out_ready` is high and no new accept happens.
- Clear: `clr` at an edge sets sum[clr_ch] ← 0 and flag[clr_ch] ← 0. It does not touch the result register.
- Clear and accept in the same cycle on the same channel: the new sum equals `in_data` (clear-then-add), the flag equals the carry of 0 + in_data (always 0), and the result reports that value.
- Clear and accept in the same cycle on different channels: both take effect independently.
- Back-to-back accepts to the same channel: each accept uses the value updated at the previous edge. There are no bubbles and no forwarding hazard.
- `in_ch`/`clr_ch` ≥ NCH (non-power-of-two NCH): the sample is accepted and dropped, no state changes, no result generated. A clear to an out-of-range channel is ignored.

## Timing
- Latency: a sample accepted at edge N has its result visible on `out_*` after edge N, i.e. in cycle N+1.
- Throughput: 1 sample/cycle while `out_ready`=1.
- Stall: with `out_ready`=0 and `out_valid`=1, `in_ready`=0 and no sample is accepted.
- `ovf_vec` reflects the flag registers and updates at the same edge as the sums.
- Reset assertion mid-transfer: all state clears asynchronously and any pending result is discarded. Deassertion is synchronised externally.

## Configuration
- `ACC_SAT_EN` defined: on carry, the sum clamps to 2^SUM_W−1 and the flag sets. Further adds hold the maximum value.
- `ACC_SAT_EN` undefined: the sum wraps modulo 2^SUM_W and the flag sets. This matches the legacy accumulator behaviour.

## Test plan
- Reset, then ch0 samples 10, 20, 30 with `out_ready`=1 → results 10, 20, 30 no wait: sums 10, 30, 60. Each result appears one cycle after accept, `out_ovf`=0.
- Interleave ch1←255, ch2←1, ch1←1 → out (1,255), (2,1), (1,256). `ovf_vec`=0.
- Preload ch3 to 65530 (SUM_W=16), add 10 → without `ACC_SAT_EN`: sum 4, `out_ovf`=1, `ovf_vec[3]`=1. With it: sum 65535, flag 1. A following add of 1 → 5 or 65535 respectively.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `out_*` stable, exactly one sample pending. Release → next sample accepted in the same cycle `out_ready` rises.
- Channel 0 at 100: assert `clr`, `clr_ch`=0 together with accept ch0←7 → result 7 and flag cleared. A separate `clr` on ch3 clears `ovf_vec[3]`.
- Assert `rst_n`=0 mid-stream with `out_valid`=1 → all outputs 0 asynchronously. After release, ch0←5 → result 5.
